// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing, text-grid and font constants for the VGA text scanner
package vga_pkg;

    // 640x480@60 timing, pixels and lines
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // Glyph cell geometry; both are powers of two so the cell split is a bit slice
    localparam int GLYPH_W = 16;
    localparam int GLYPH_H = 32;
    localparam int GX_W    = $clog2(GLYPH_W);
    localparam int GY_W    = $clog2(GLYPH_H);

    // Text grid for the default timing
    localparam int COLS = VGA_H_ACTIVE / GLYPH_W;
    localparam int ROWS = VGA_V_ACTIVE / GLYPH_H;

    // Widths
    localparam int CNT_W     = 10;
    localparam int TXT_AW    = 10;
    localparam int TXT_DW    = 8;
    localparam int TXT_DEPTH = 1 << TXT_AW;
    localparam int FT_W      = 7;
    localparam int FA_W      = 11;
    localparam int RGB_W     = 12;

    // Printable ASCII range covered by the font ROM
    localparam logic [TXT_DW-1:0] FONT_BASE = 8'h20;
    localparam logic [TXT_DW-1:0] FONT_END  = 8'h80;

    // Map an ASCII code to a font ROM glyph; anything unprintable shows as a space
    function automatic logic [FT_W-1:0] glyph_index(input logic [TXT_DW-1:0] code);
        logic [TXT_DW-1:0] off;
        off = code - FONT_BASE;
        if ((code >= FONT_BASE) && (code < FONT_END)) begin
            return off[FT_W-1:0];
        end
        return '0;
    endfunction

endpackage

// File: rtl/vga_text_ram.sv
// rtl/vga_text_ram.sv - 1024x8 simple dual-port text buffer, registered read, old data on collision
module vga_text_ram
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [TXT_AW-1:0] wr_addr,
    input  logic [TXT_DW-1:0] wr_data,
    input  logic [TXT_AW-1:0] rd_addr,
    output logic [TXT_DW-1:0] rd_data
);

    logic [TXT_DW-1:0] mem [0:TXT_DEPTH-1];

    // Write port and registered read port; a same-address read sees the pre-write word
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/vga_text_scan.sv
// rtl/vga_text_scan.sv - VGA sync generator, text-buffer walker, font ROM driver and colour mux
module vga_text_scan
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [TXT_AW-1:0] wr_addr,
    input  logic [TXT_DW-1:0] wr_data,
    input  logic [RGB_W-1:0]  fg_color,
    input  logic [RGB_W-1:0]  bg_color,
    output logic [FT_W-1:0]   font_type,
    output logic [FA_W-1:0]   font_addr,
    input  logic              font_bit,
    output logic              hsync,
    output logic              vsync,
    output logic [RGB_W-1:0]  rgb,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int N_COLS  = H_ACTIVE / GLYPH_W;
    localparam int N_CELLS = N_COLS * (V_ACTIVE / GLYPH_H);

    localparam logic [CNT_W-1:0]  H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0]  V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0]  H_ACT_END = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0]  V_ACT_END = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0]  HS_FIRST  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0]  HS_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0]  VS_FIRST  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0]  VS_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [TXT_AW-1:0] COLS_L    = TXT_AW'(N_COLS);
    localparam logic [TXT_AW:0]   CELLS_L   = (TXT_AW + 1)'(N_CELLS);

    // Raster position
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;

    // Stage 0 decode of the raster position
    logic              de0;
    logic              hs0;
    logic              vs0;
    logic              fs0;
    logic [TXT_AW-1:0] txt_row;
    logic [TXT_AW-1:0] txt_col;
    logic [TXT_AW-1:0] rd_addr;
    logic              wr_ok;

    // Stage 1: text RAM word plus cell-relative coordinates
    logic [TXT_DW-1:0] ram_q;
    logic [GX_W-1:0]   gx1;
    logic [GY_W-1:0]   gy1;
    logic              de1, hs1, vs1, fs1;

    // Stage 2 and 3 delay line alongside the font ROM access
    logic              de2, hs2, vs2, fs2;
    logic              de3, hs3, vs3, fs3;

    // Horizontal and vertical raster counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Decode active area, sync windows, frame origin and the text cell under the beam
    always_comb begin
        de0     = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        hs0     = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
        vs0     = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
        fs0     = (h_cnt == '0) && (v_cnt == '0);
        txt_row = TXT_AW'(v_cnt >> GY_W);
        txt_col = TXT_AW'(h_cnt >> GX_W);
        rd_addr = txt_row * COLS_L + txt_col;
    end

    // Writes beyond the visible grid are dropped rather than landing in spare RAM
    assign wr_ok = wr_en && ({1'b0, wr_addr} < CELLS_L);

    vga_text_ram u_text_ram (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    // Stage 1: register pixel position within the glyph and the control bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gx1 <= '0;
            gy1 <= '0;
            de1 <= 1'b0;
            hs1 <= 1'b1;
            vs1 <= 1'b1;
            fs1 <= 1'b0;
        end else begin
            gx1 <= h_cnt[GX_W-1:0];
            gy1 <= v_cnt[GY_W-1:0];
            de1 <= de0;
            hs1 <= hs0;
            vs1 <= vs0;
            fs1 <= fs0;
        end
    end

    // Stage 2: present glyph and pixel index to the font ROM; hold them during blanking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            font_type <= '0;
            font_addr <= '0;
            de2       <= 1'b0;
            hs2       <= 1'b1;
            vs2       <= 1'b1;
            fs2       <= 1'b0;
        end else begin
            if (de1) begin
                font_type <= glyph_index(ram_q);
                font_addr <= FA_W'({gy1, gx1});
            end
            de2 <= de1;
            hs2 <= hs1;
            vs2 <= vs1;
            fs2 <= fs1;
        end
    end

    // Stage 3: wait out the font ROM read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de3 <= 1'b0;
            hs3 <= 1'b1;
            vs3 <= 1'b1;
            fs3 <= 1'b0;
        end else begin
            de3 <= de2;
            hs3 <= hs2;
            vs3 <= vs2;
            fs3 <= fs2;
        end
    end

    // Stage 4: colour the pixel and drive the pins, all on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb         <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            rgb         <= de3 ? (font_bit ? fg_color : bg_color) : '0;
            hsync       <= hs3;
            vsync       <= vs3;
            frame_start <= fs3;
        end
    end

endmodule

// File: tb/tb_vga_text_scan.sv
// tb/tb_vga_text_scan.sv - randomized bench for vga_text_scan against a raster reference model
module tb_vga_text_scan;

    localparam int HA = 640, HFP = 16, HSW = 96, HBP = 48;
    localparam int VA = 64,  VFP = 2,  VSW = 2,  VBP = 3;
    localparam int HT     = HA + HFP + HSW + HBP;
    localparam int VT     = VA + VFP + VSW + VBP;
    localparam int FRAME  = HT * VT;
    localparam int NCOLS  = HA / 16;
    localparam int NCELLS = NCOLS * (VA / 32);

    typedef struct {
        int          h;
        int          v;
        logic [6:0]  ft;
        logic [10:0] fa;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [11:0] rgb;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [9:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [11:0] fg_color;
    logic [11:0] bg_color;
    logic [6:0]  font_type;
    logic [10:0] font_addr;
    logic        font_bit = 1'b0;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
    logic        frame_start;

    int n_tests = 0;
    int n_fail  = 0;

    vga_text_scan #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .fg_color    (fg_color),
        .bg_color    (bg_color),
        .font_type   (font_type),
        .font_addr   (font_addr),
        .font_bit    (font_bit),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic rom_bit(input logic [6:0] t, input logic [10:0] a);
        return ~a[0] ^ (^(t[2:0] & a[6:4]));
    endfunction

    // Font ROM: one clock of read latency
    always @(posedge clk) font_bit <= rom_bit(font_type, font_addr);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference model: what each raster position should look like, straight from the rules
    logic [7:0]  text_m [0:1023];
    rec_t        q[$];
    int          s = 0;
    logic [6:0]  last_ft = '0;
    logic [10:0] last_fa = '0;
    rec_t        mr;
    logic [7:0]  mcode;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            s = 0;
            last_ft = '0;
            last_fa = '0;
        end else begin
            mr.h  = s % HT;
            mr.v  = (s / HT) % VT;
            mr.hs = !(mr.h >= HA + HFP && mr.h < HA + HFP + HSW);
            mr.vs = !(mr.v >= VA + VFP && mr.v < VA + VFP + VSW);
            mr.fs = (mr.h == 0) && (mr.v == 0);
            if (mr.h < HA && mr.v < VA) begin
                mcode   = text_m[(mr.v / 32) * NCOLS + mr.h / 16];
                last_ft = (mcode >= 8'h20 && mcode < 8'h80) ? 7'(mcode - 8'h20) : 7'd0;
                last_fa = 11'((mr.v % 32) * 16 + mr.h % 16);
                mr.rgb  = rom_bit(last_ft, last_fa) ? fg_color : bg_color;
            end else begin
                mr.rgb = '0;
            end
            mr.ft = last_ft;
            mr.fa = last_fa;
            q.push_back(mr);
            s++;
            if (q.size() > 8) void'(q.pop_front());
        end
        if (wr_en && int'(wr_addr) < NCELLS) text_m[wr_addr] = wr_data;
    end

    int   hs_falls[$];
    int   fs_times[$];
    int   vs_low = 0;
    logic prev_hsync = 1'b1;
    bit   directed_ok = 1'b0;

    task automatic check_cycle();
        logic [63:0] got, want;
        logic [14:0] pins;
        logic [17:0] fnt;
        rec_t        r;
        int          n;
        n    = q.size();
        pins = (rst || n < 4) ? {1'b1, 1'b1, 1'b0, 12'h000}
                              : {q[n-4].hs, q[n-4].vs, q[n-4].fs, q[n-4].rgb};
        fnt  = (rst || n < 2) ? 18'h0 : {q[n-2].ft, q[n-2].fa};
        got  = {31'b0, hsync, vsync, frame_start, rgb, font_type, font_addr};
        want = {31'b0, pins, fnt};
        check_eq($sformatf("px s=%0d", s), got, want);
        if (!rst && n >= 2 && directed_ok) begin
            r = q[n-2];
            if (r.v == 0 && r.h == 5) begin
                check_eq("cell0_type", 64'(font_type), 64'd33);
                check_eq("cell0_addr", 64'(font_addr), 64'd5);
            end
            if (r.v == 1 && r.h == 3)       check_eq("cell0_line1_addr", 64'(font_addr), 64'd19);
            if (r.v == 0 && r.h == 39*16+2) check_eq("ctrl_code_type", 64'(font_type), 64'd0);
            if (r.v == 32 && r.h == 2)      check_eq("del_code_type", 64'(font_type), 64'd95);
        end
        if (!rst) begin
            if (prev_hsync && !hsync) hs_falls.push_back(s);
            if (!vsync && s <= FRAME) vs_low++;
            if (frame_start) fs_times.push_back(s);
        end
        prev_hsync = hsync;
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic check_reset_pins(input string pfx);
        check_eq({pfx, "_hsync"}, 64'(hsync), 64'd1);
        check_eq({pfx, "_vsync"}, 64'(vsync), 64'd1);
        check_eq({pfx, "_rgb"}, 64'(rgb), 64'd0);
        check_eq({pfx, "_font_type"}, 64'(font_type), 64'd0);
        check_eq({pfx, "_font_addr"}, 64'(font_addr), 64'd0);
        check_eq({pfx, "_frame_start"}, 64'(frame_start), 64'd0);
    endtask

    task automatic write_cell(input int a, input logic [7:0] d);
        tick();
        wr_en   = 1'b1;
        wr_addr = 10'(a);
        wr_data = d;
    endtask

    initial begin
        fg_color = 12'($urandom);
        bg_color = fg_color ^ 12'hA5C;
        repeat (3) tick();
        check_reset_pins("rst");

        // Fill the visible grid while held in reset, then place the directed codes
        for (int a = 0; a < NCELLS; a++) write_cell(a, 8'($urandom));
        write_cell(0, 8'h41);
        write_cell(39, 8'h05);
        write_cell(40, 8'h7F);
        write_cell(700, 8'h33);
        tick();
        wr_en = 1'b0;

        rst = 1'b0;
        directed_ok = 1'b1;
        while (s < VA * HT) tick();
        directed_ok = 1'b0;

        // Random rewrites through the blanking and second frame, one collision on cell 5
        while (s < FRAME + 5 * HT + 300) begin
            tick();
            wr_en = 1'b0;
            if (s == FRAME + 3 * HT + 88) begin
                wr_en   = 1'b1;
                wr_addr = 10'd5;
                wr_data = ~text_m[5];
            end else if ($urandom_range(0, 5) == 0) begin
                wr_en   = 1'b1;
                wr_addr = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(NCELLS, 1023))
                                                      : 10'($urandom_range(0, NCELLS - 1));
                wr_data = 8'($urandom);
            end
        end

        check_eq("hsync_first_fall", 64'(hs_falls.size() > 0 ? hs_falls[0] : -1), 64'(660));
        check_eq("line_length", 64'(hs_falls.size() > 1 ? hs_falls[1] - hs_falls[0] : -1), 64'(HT));
        check_eq("vsync_low_cycles", 64'(vs_low), 64'(VSW * HT));
        check_eq("frame_start_first", 64'(fs_times.size() > 0 ? fs_times[0] : -1), 64'(4));
        check_eq("frame_length", 64'(fs_times.size() > 1 ? fs_times[1] - fs_times[0] : -1), 64'(FRAME));

        // Reset in the middle of a line: pins go idle immediately, timing restarts
        rst   = 1'b1;
        wr_en = 1'b0;
        #1;
        check_reset_pins("midrst");
        repeat (3) tick();
        hs_falls.delete();
        fs_times.delete();
        rst = 1'b0;
        while (s < 2 * HT) tick();
        check_eq("midrst_frame_start", 64'(fs_times.size() > 0 ? fs_times[0] : -1), 64'(4));
        check_eq("midrst_hsync_fall", 64'(hs_falls.size() > 0 ? hs_falls[0] : -1), 64'(660));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
